mux_share_arbiter: RTL and testbench

- Round-robin controller that shares the gate-level 2:1 selector datapath (z = sel ? b : a) between two requesters, A and B.
- Owns the select line and grants one requester at a time under a req/gnt handshake.
- Registers the selected data onto a single shared output with a valid flag.
- Sits between the two requesting lab units and the downstream consumer of z.

---
 rtl/mux_share_arbiter.sv | 83 ++++++++
 tb/tb_mux_share_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin owner of a shared 2:1 selector (z = sel ? b : a) with registered output.
//   Ports: clk, rst_n (sync, active-low); req_a/req_b requests; a_data/b_data requester data;
//          gnt_a/gnt_b one-hot grants; sel selector control (0=A, 1=B); z registered selected data;
//          z_valid z holds granted data; preempt one-cycle pulse on forced hand-over.
//   Optional feature: define MUX_SHARE_ARBITER_PREEMPT_EN to force hand-over after MAX_HOLD owned
//          cycles when the other requester waits; otherwise owners hold while req is high.
module mux_share_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] z,
  output logic             z_valid,
  output logic             preempt
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t           r_state, w_state_next;
  logic             r_last_b, r_sel, r_z_valid, r_preempt;
  logic             w_sel_next, w_preempt_next, w_hold_due;
  logic [HW-1:0]    r_hold;
  logic [WIDTH-1:0] r_z;
`ifdef MUX_SHARE_ARBITER_PREEMPT_EN
  assign w_hold_due = r_hold == HW'(MAX_HOLD - 1);
`else
  logic w_unused_hold;
  assign w_unused_hold = ^r_hold;
  assign w_hold_due    = 1'b0;
`endif
  always_comb begin
    w_state_next   = r_state;
    w_preempt_next = 1'b0;
    case (r_state)
      IDLE:    w_state_next = (req_a && req_b) ? (r_last_b ? OWN_A : OWN_B) :
                              req_a ? OWN_A : req_b ? OWN_B : IDLE;
      OWN_A: begin
        w_state_next   = !req_a ? (req_b ? OWN_B : IDLE) : (req_b && w_hold_due) ? OWN_B : OWN_A;
        w_preempt_next = req_a && req_b && w_hold_due;
      end
      OWN_B: begin
        w_state_next   = !req_b ? (req_a ? OWN_A : IDLE) : (req_a && w_hold_due) ? OWN_A : OWN_B;
        w_preempt_next = req_a && req_b && w_hold_due;
      end
      default: w_state_next = IDLE;
    endcase
    w_sel_next = (w_state_next == OWN_B) ? 1'b1 : (w_state_next == OWN_A) ? 1'b0 : r_sel;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_b  <= 1'b1;
      r_hold    <= '0;
      r_sel     <= 1'b0;
      r_z       <= '0;
      r_z_valid <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      if (r_state != IDLE && w_state_next != r_state) r_last_b <= (r_state == OWN_B);
      // any state change (including A->B hand-over) is an entry, so the count restarts
      r_hold    <= (r_state == IDLE || w_state_next != r_state) ? '0 :
                   (r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + 1'b1;
      r_sel     <= w_sel_next;
      if (w_state_next != IDLE) r_z <= w_sel_next ? b_data : a_data;
      r_z_valid <= w_state_next != IDLE;
      r_preempt <= w_preempt_next;
    end
  end
  assign gnt_a   = r_state == OWN_A;
  assign gnt_b   = r_state == OWN_B;
  assign sel     = r_sel;
  assign z       = r_z;
  assign z_valid = r_z_valid;
  assign preempt = r_preempt;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed vector table, hold/preempt sequence and random run against a reference model.
module tb_mux_share_arbiter;
  localparam int W  = 4;
  localparam int MH = 3;
`ifdef MUX_SHARE_ARBITER_PREEMPT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] a_data = '0, b_data = '0, z;
  logic gnt_a, gnt_b, sel, z_valid, preempt;
  int checks = 0, errs = 0;
  mux_share_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a_data(a_data), .b_data(b_data),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .z(z), .z_valid(z_valid), .preempt(preempt));
  always #5 clk = ~clk;
  typedef struct {
    logic rst_n, ra, rb;
    logic [W-1:0] ad, bd;
    logic [W+4:0] exp;
  } vec_t;
  vec_t v[21];
  int m_own, m_last, m_hold;
  logic m_sel, m_zv, m_pre;
  logic [W-1:0] m_z;
  function automatic logic [W+4:0] pk(logic ga, gb, s, logic [W-1:0] zz, logic zv, pr);
    return {ga, gb, s, zz, zv, pr};
  endfunction
  task automatic drive(logic r, ra, rb, logic [W-1:0] ad, bd);
    rst_n = r; req_a = ra; req_b = rb; a_data = ad; b_data = bd;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, int idx, logic [W+4:0] exp);
    logic [W+4:0] act;
    act = {gnt_a, gnt_b, sel, z, z_valid, preempt};
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got {ga,gb,sel,z,zv,pre}=%b expected %b", nm, idx, act, exp);
    end
  endtask
  task automatic model_step(logic r, ra, rb, logic [W-1:0] ad, bd);
    int n;
    logic due;
    if (!r) begin
      m_own = 0; m_last = 2; m_hold = 0; m_sel = 0; m_z = '0; m_zv = 0; m_pre = 0;
      return;
    end
    due = PE && (m_hold == MH - 1);
    m_pre = 0;
    if (m_own == 0) n = (ra && rb) ? ((m_last == 2) ? 1 : 2) : ra ? 1 : rb ? 2 : 0;
    else if (m_own == 1) begin
      n = !ra ? (rb ? 2 : 0) : (rb && due) ? 2 : 1;
      m_pre = ra && rb && due;
    end else begin
      n = !rb ? (ra ? 1 : 0) : (ra && due) ? 1 : 2;
      m_pre = ra && rb && due;
    end
    if (m_own != 0 && n != m_own) m_last = m_own;
    m_hold = (m_own == 0 || n != m_own) ? 0 : (m_hold == MH) ? m_hold : m_hold + 1;
    if (n == 1) m_sel = 0;
    else if (n == 2) m_sel = 1;
    if (n != 0) m_z = m_sel ? bd : ad;
    m_zv = n != 0;
    m_own = n;
  endtask
  initial begin
    v[0]  = '{0, 0, 0, 4'd0,  4'd0,  pk(0, 0, 0, 4'd0,  0, 0)};
    v[1]  = '{1, 1, 0, 4'd1,  4'd0,  pk(1, 0, 0, 4'd1,  1, 0)};
    v[2]  = '{0, 1, 0, 4'd1,  4'd0,  pk(0, 0, 0, 4'd0,  0, 0)};
    v[3]  = '{1, 1, 1, 4'd2,  4'd3,  pk(1, 0, 0, 4'd2,  1, 0)};
    v[4]  = '{1, 0, 1, 4'd2,  4'd3,  pk(0, 1, 1, 4'd3,  1, 0)};
    v[5]  = '{1, 0, 0, 4'd2,  4'd3,  pk(0, 0, 1, 4'd3,  0, 0)};
    v[6]  = '{1, 1, 1, 4'd4,  4'd5,  pk(1, 0, 0, 4'd4,  1, 0)};
    v[7]  = '{1, 0, 0, 4'd4,  4'd5,  pk(0, 0, 0, 4'd4,  0, 0)};
    v[8]  = '{1, 1, 1, 4'd6,  4'd7,  pk(0, 1, 1, 4'd7,  1, 0)};
    v[9]  = '{1, 0, 0, 4'd6,  4'd7,  pk(0, 0, 1, 4'd7,  0, 0)};
    v[10] = '{1, 1, 1, 4'd8,  4'd9,  pk(1, 0, 0, 4'd8,  1, 0)};
    v[11] = '{1, 0, 0, 4'd8,  4'd9,  pk(0, 0, 0, 4'd8,  0, 0)};
    v[12] = '{1, 1, 1, 4'd10, 4'd11, pk(0, 1, 1, 4'd11, 1, 0)};
    v[13] = '{1, 0, 0, 4'd10, 4'd11, pk(0, 0, 1, 4'd11, 0, 0)};
    v[14] = '{1, 0, 1, 4'd0,  4'd0,  pk(0, 1, 1, 4'd0,  1, 0)};
    v[15] = '{1, 0, 1, 4'd0,  4'd1,  pk(0, 1, 1, 4'd1,  1, 0)};
    v[16] = '{1, 0, 1, 4'd0,  4'd0,  pk(0, 1, 1, 4'd0,  1, 0)};
    v[17] = '{1, 0, 0, 4'd5,  4'd15, pk(0, 0, 1, 4'd0,  0, 0)};
    v[18] = '{1, 1, 0, 4'd9,  4'd2,  pk(1, 0, 0, 4'd9,  1, 0)};
    v[19] = '{1, 1, 1, 4'd6,  4'd2,  pk(1, 0, 0, 4'd6,  1, 0)};
    v[20] = '{1, 0, 1, 4'd6,  4'd2,  pk(0, 1, 1, 4'd2,  1, 0)};
    for (int i = 0; i < 21; i++) begin
      drive(v[i].rst_n, v[i].ra, v[i].rb, v[i].ad, v[i].bd);
      chk("vec", i, v[i].exp);
    end
    drive(0, 0, 0, 4'd0, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      logic own_b, pr;
      own_b = PE && (((k - 1) / MH) % 2 == 1);
      pr    = PE && k > 1 && ((k - 1) % MH == 0);
      drive(1, 1, 1, 4'd3, 4'd12);
      chk("hold", k, pk(!own_b, own_b, own_b, own_b ? 4'd12 : 4'd3, 1, pr));
    end
    model_step(0, 0, 0, '0, '0);
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 1000; i++) begin
      logic r, ra, rb;
      logic [W-1:0] ad, bd;
      r  = $urandom_range(99) != 0;
      ra = $urandom_range(2) != 0;
      rb = $urandom_range(2) != 0;
      ad = W'($urandom);
      bd = W'($urandom);
      model_step(r, ra, rb, ad, bd);
      drive(r, ra, rb, ad, bd);
      chk("rand", i, pk(m_own == 1, m_own == 2, m_sel, m_z, m_zv, m_pre));
    end
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
